// File: rtl/mmio_fifo_bridge.sv
// mmio_fifo_bridge: MMIO register front-end over per-channel TX/RX FIFOs.
// Writes push TX FIFOs or update control state. Reads pop RX FIFOs through
// a three-state read FSM (IDLE -> LOOKUP -> RESP).
module mmio_fifo_bridge #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0510
) (
    input  logic                 clk_main_a0,
    input  logic                 rst_main_sync,
    input  logic                 wr_valid,
    input  logic [31:0]          wr_addr,
    input  logic [31:0]          wdata,
    input  logic                 arvalid_q,
    input  logic [31:0]          araddr_q,
    output logic                 arready,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [31:0]          rdata,
    output logic [1:0]           rresp,
    output logic [32*NUM_CH-1:0] tx_data,
    output logic [NUM_CH-1:0]    tx_valid,
    input  logic [NUM_CH-1:0]    tx_ready,
    input  logic [32*NUM_CH-1:0] rx_data,
    input  logic [NUM_CH-1:0]    rx_valid,
    output logic [NUM_CH-1:0]    rx_ready,
    output logic                 irq
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam logic [31:0] SPAN = 32'(16 * NUM_CH);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} rd_state_t;

    rd_state_t state, state_nxt;

    logic [31:0]   tx_mem    [NUM_CH][DEPTH];
    logic [31:0]   rx_mem    [NUM_CH][DEPTH];
    logic [AW-1:0] tx_wr_ptr [NUM_CH];
    logic [AW-1:0] tx_rd_ptr [NUM_CH];
    logic [AW-1:0] rx_wr_ptr [NUM_CH];
    logic [AW-1:0] rx_rd_ptr [NUM_CH];
    logic [LW-1:0] tx_level  [NUM_CH];
    logic [LW-1:0] rx_level  [NUM_CH];

    logic [NUM_CH-1:0] tx_full, tx_empty, rx_full, rx_empty;
    logic [NUM_CH-1:0] tx_push, tx_pop, tx_flush;
    logic [NUM_CH-1:0] rx_push, rx_pop, rx_flush;
    logic [NUM_CH-1:0] ctrl_wr, ovf_set, udf_set, ovf_clr, udf_clr;
    logic [NUM_CH-1:0] irq_en, tx_ovf, rx_udf;

    logic [31:0] wr_off, rd_off, rd_addr;
    logic        wr_hit, rd_hit;
    logic [31:0] rd_word;
    logic [1:0]  rd_resp;

    // Address decode: offsets outside the channel window or not word-aligned are unmapped.
    assign wr_off = wr_addr - BASE_ADDR;
    assign rd_off = rd_addr - BASE_ADDR;
    assign wr_hit = wr_valid && (wr_off < SPAN) && (wr_off[1:0] == 2'b00);
    assign rd_hit = (rd_off < SPAN) && (rd_off[1:0] == 2'b00);

    // Per-channel flags and FIFO/control strobes.
    always_comb begin
        tx_full  = '0;
        tx_empty = '0;
        rx_full  = '0;
        rx_empty = '0;
        tx_push  = '0;
        tx_pop   = '0;
        tx_flush = '0;
        rx_push  = '0;
        rx_pop   = '0;
        rx_flush = '0;
        ctrl_wr  = '0;
        ovf_set  = '0;
        udf_set  = '0;
        ovf_clr  = '0;
        udf_clr  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            tx_full[c]  = (tx_level[c] == LW'(DEPTH));
            tx_empty[c] = (tx_level[c] == '0);
            rx_full[c]  = (rx_level[c] == LW'(DEPTH));
            rx_empty[c] = (rx_level[c] == '0);
            if (wr_hit && wr_off[5:4] == 2'(c)) begin
                case (wr_off[3:2])
                    2'd0: begin
                        tx_push[c] = !tx_full[c];
                        ovf_set[c] = tx_full[c];
                    end
                    2'd2: begin
                        ctrl_wr[c]  = 1'b1;
                        tx_flush[c] = wdata[0];
                        rx_flush[c] = wdata[1];
                    end
                    2'd3: begin
                        ovf_clr[c] = wdata[0];
                        udf_clr[c] = wdata[1];
                    end
                    default: ;
                endcase
            end
            tx_pop[c]  = !tx_empty[c] && tx_ready[c];
            rx_push[c] = rx_valid[c] && !rx_full[c];
            if (state == LOOKUP && rd_hit && rd_off[5:4] == 2'(c) && rd_off[3:2] == 2'd0) begin
                rx_pop[c]  = !rx_empty[c];
                udf_set[c] = rx_empty[c];
            end
        end
    end

    // Streaming side: first-word-fall-through TX, RX ready while not full.
    always_comb begin
        tx_data = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            tx_data[c*32 +: 32] = tx_mem[c][tx_rd_ptr[c]];
        end
        tx_valid = ~tx_empty;
        rx_ready = ~rx_full;
    end

    // FIFO storage writes (no reset needed for contents).
    always_ff @(posedge clk_main_a0) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (tx_push[c]) tx_mem[c][tx_wr_ptr[c]] <= wdata;
            if (rx_push[c]) rx_mem[c][rx_wr_ptr[c]] <= rx_data[c*32 +: 32];
        end
    end

    // FIFO pointers/levels, control and sticky state; flush beats push/pop, sticky set beats clear.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                tx_wr_ptr[c] <= '0;
                tx_rd_ptr[c] <= '0;
                rx_wr_ptr[c] <= '0;
                rx_rd_ptr[c] <= '0;
                tx_level[c]  <= '0;
                rx_level[c]  <= '0;
            end
            irq_en <= '0;
            tx_ovf <= '0;
            rx_udf <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (tx_flush[c]) begin
                    tx_wr_ptr[c] <= '0;
                    tx_rd_ptr[c] <= '0;
                    tx_level[c]  <= '0;
                end else begin
                    if (tx_push[c]) tx_wr_ptr[c] <= tx_wr_ptr[c] + AW'(1);
                    if (tx_pop[c])  tx_rd_ptr[c] <= tx_rd_ptr[c] + AW'(1);
                    tx_level[c] <= tx_level[c] + LW'(tx_push[c]) - LW'(tx_pop[c]);
                end
                if (rx_flush[c]) begin
                    rx_wr_ptr[c] <= '0;
                    rx_rd_ptr[c] <= '0;
                    rx_level[c]  <= '0;
                end else begin
                    if (rx_push[c]) rx_wr_ptr[c] <= rx_wr_ptr[c] + AW'(1);
                    if (rx_pop[c])  rx_rd_ptr[c] <= rx_rd_ptr[c] + AW'(1);
                    rx_level[c] <= rx_level[c] + LW'(rx_push[c]) - LW'(rx_pop[c]);
                end
                if (ctrl_wr[c]) irq_en[c] <= wdata[2];
            end
            tx_ovf <= (tx_ovf & ~ovf_clr) | ovf_set;
            rx_udf <= (rx_udf & ~udf_clr) | udf_set;
        end
    end

    // Read data mux for the captured address.
    always_comb begin
        rd_word = 32'hAAAA_AAAA;
        rd_resp = 2'b10;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rd_hit && rd_off[5:4] == 2'(c)) begin
                rd_resp = 2'b00;
                case (rd_off[3:2])
                    2'd0:    rd_word = rx_empty[c] ? 32'hDEAD_0000 : rx_mem[c][rx_rd_ptr[c]];
                    2'd1:    rd_word = {rx_empty[c], rx_full[c], tx_empty[c], tx_full[c], 3'b000,
                                        9'(rx_level[c]), 7'b0000000, 9'(tx_level[c])};
                    2'd2:    rd_word = {29'd0, irq_en[c], 2'b00};
                    default: rd_word = {30'd0, rx_udf[c], tx_ovf[c]};
                endcase
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) state <= IDLE;
        else               state <= state_nxt;
    end

    // Read FSM next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        arready   = (state == IDLE);
        rvalid    = (state == RESP);
        case (state)
            IDLE:    if (arvalid_q) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = RESP;
            RESP:    if (rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address capture on handshake; response registered in LOOKUP and held through RESP.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            rd_addr <= '0;
            rdata   <= '0;
            rresp   <= '0;
        end else begin
            if (state == IDLE && arvalid_q) rd_addr <= araddr_q;
            if (state == LOOKUP) begin
                rdata <= rd_word;
                rresp <= rd_resp;
            end
        end
    end

    // Registered interrupt: any enabled channel with RX data pending.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) irq <= 1'b0;
        else               irq <= |(irq_en & ~rx_empty);
    end

endmodule

// File: tb/tb_mmio_fifo_bridge.sv
// tb_mmio_fifo_bridge: directed self-checking bench for mmio_fifo_bridge
// (NUM_CH=2, DEPTH=4, default BASE_ADDR).
module tb_mmio_fifo_bridge;

    logic        clk_main_a0;
    logic        rst_main_sync;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wdata;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic        arready;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [63:0] tx_data;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_ready;
    logic [63:0] rx_data;
    logic [1:0]  rx_valid;
    logic [1:0]  rx_ready;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    mmio_fifo_bridge #(
        .NUM_CH    (2),
        .DEPTH     (4),
        .BASE_ADDR (32'h0000_0510)
    ) dut (
        .clk_main_a0   (clk_main_a0),
        .rst_main_sync (rst_main_sync),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wdata         (wdata),
        .arvalid_q     (arvalid_q),
        .araddr_q      (araddr_q),
        .arready       (arready),
        .rvalid        (rvalid),
        .rready        (rready),
        .rdata         (rdata),
        .rresp         (rresp),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .irq           (irq)
    );

    initial clk_main_a0 = 1'b0;
    always #5 clk_main_a0 = ~clk_main_a0;

    task automatic tick();
        @(posedge clk_main_a0);
        #1;
    endtask

    task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wdata    = data;
        tick();
        wr_valid = 1'b0;
    endtask

    // Handshake, wait (bounded) for rvalid, capture response, then accept it.
    task automatic mmio_read(input logic [31:0] addr, output logic [31:0] data,
                             output logic [1:0] resp, output int lat);
        arvalid_q = 1'b1;
        araddr_q  = addr;
        tick();
        arvalid_q = 1'b0;
        lat = 1;
        while (rvalid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        if (rvalid !== 1'b1) lat = 99;
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic rx_push(input int ch, input logic [31:0] data);
        rx_valid[ch] = 1'b1;
        rx_data[ch*32 +: 32] = data;
        tick();
        rx_valid[ch] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        rst_main_sync = 1'b1;
        tick();
        tick();
        rst_main_sync = 1'b0;
        n_cmp++; if (arready !== 1'b1) begin n_err++; $display("FAIL reset_arready got=%b exp=1", arready); end
        n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        n_cmp++; if (rresp !== 2'b00) begin n_err++; $display("FAIL reset_rresp got=%b exp=00", rresp); end
        n_cmp++; if (tx_valid !== 2'b00) begin n_err++; $display("FAIL reset_tx_valid got=%b exp=00", tx_valid); end
        n_cmp++; if (rx_ready !== 2'b11) begin n_err++; $display("FAIL reset_rx_ready got=%b exp=11", rx_ready); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
        mmio_read(32'h514, d, r, lat);
        n_cmp++; if (d !== 32'hA000_0000) begin n_err++; $display("FAIL reset_status got=%h exp=a0000000", d); end
        mmio_read(32'h51C, d, r, lat);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_sticky got=%h exp=0", d); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        tx_ready = 2'b00;
        for (int i = 1; i <= 5; i++) mmio_write(32'h510, 32'(i));
        mmio_read(32'h514, d, r, lat);
        n_cmp++; if (d !== 32'h9000_0004) begin n_err++; $display("FAIL ovf_status got=%h exp=90000004", d); end
        mmio_read(32'h51C, d, r, lat);
        n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL ovf_sticky got=%h exp=1", d); end
        tx_ready[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (tx_valid[0] !== 1'b1 || tx_data[31:0] !== 32'(k)) begin
                n_err++; $display("FAIL ovf_drain got=%b/%h exp=1/%h", tx_valid[0], tx_data[31:0], 32'(k));
            end
            tick();
        end
        tx_ready[0] = 1'b0;
        n_cmp++; if (tx_valid[0] !== 1'b0) begin n_err++; $display("FAIL ovf_empty got=%b exp=0", tx_valid[0]); end
        mmio_write(32'h51C, 32'h1);
        mmio_read(32'h51C, d, r, lat);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL ovf_w1c got=%h exp=0", d); end
    endtask

    task automatic test_rx_read();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        rx_push(1, 32'hCAFE_0001);
        mmio_read(32'h520, d, r, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL rx_latency got=%0d exp=2", lat); end
        n_cmp++; if (d !== 32'hCAFE_0001) begin n_err++; $display("FAIL rx_data got=%h exp=cafe0001", d); end
        n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL rx_resp got=%b exp=00", r); end
        mmio_read(32'h520, d, r, lat);
        n_cmp++; if (d !== 32'hDEAD_0000 || r !== 2'b00) begin n_err++; $display("FAIL rx_underflow got=%h/%b exp=dead0000/00", d, r); end
        mmio_read(32'h52C, d, r, lat);
        n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL rx_udf got=%h exp=2", d); end
        mmio_write(32'h52C, 32'h2);
        mmio_read(32'h52C, d, r, lat);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rx_udf_clr got=%h exp=0", d); end
        rx_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_data[63:32] = 32'h100 + 32'(i);
            tick();
        end
        rx_valid[1] = 1'b0;
        n_cmp++; if (rx_ready[1] !== 1'b0) begin n_err++; $display("FAIL rx_full_ready got=%b exp=0", rx_ready[1]); end
        mmio_read(32'h524, d, r, lat);
        n_cmp++; if (d !== 32'h6004_0000) begin n_err++; $display("FAIL rx_full_status got=%h exp=60040000", d); end
        mmio_write(32'h528, 32'h2);
        n_cmp++; if (rx_ready[1] !== 1'b1) begin n_err++; $display("FAIL rx_flush_ready got=%b exp=1", rx_ready[1]); end
        mmio_read(32'h524, d, r, lat);
        n_cmp++; if (d !== 32'hA000_0000) begin n_err++; $display("FAIL rx_flush_status got=%h exp=a0000000", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        mmio_read(32'h550, d, r, lat);
        n_cmp++; if (d !== 32'hAAAA_AAAA || r !== 2'b10) begin n_err++; $display("FAIL unmapped_hi got=%h/%b exp=aaaaaaaa/10", d, r); end
        mmio_read(32'h500, d, r, lat);
        n_cmp++; if (d !== 32'hAAAA_AAAA || r !== 2'b10) begin n_err++; $display("FAIL unmapped_lo got=%h/%b exp=aaaaaaaa/10", d, r); end
        mmio_write(32'h514, 32'hFFFF_FFFF);
        mmio_read(32'h514, d, r, lat);
        n_cmp++; if (d !== 32'hA000_0000) begin n_err++; $display("FAIL status_ro got=%h exp=a0000000", d); end
    endtask

    task automatic test_rready_stall();
        rx_push(0, 32'h1234_5678);
        arvalid_q = 1'b1;
        araddr_q  = 32'h510;
        tick();
        arvalid_q = 1'b0;
        n_cmp++; if (arready !== 1'b0) begin n_err++; $display("FAIL stall_lookup_arready got=%b exp=0", arready); end
        wr_valid = 1'b1;
        wr_addr  = 32'h520;
        wdata    = 32'h0000_BEEF;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || arready !== 1'b0) begin
                n_err++; $display("FAIL stall_hold got=%b/%h/%b exp=1/12345678/0", rvalid, rdata, arready);
            end
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        n_cmp++; if (rvalid !== 1'b0 || arready !== 1'b1) begin n_err++; $display("FAIL stall_release got=%b/%b exp=0/1", rvalid, arready); end
        n_cmp++; if (tx_valid[1] !== 1'b1 || tx_data[63:32] !== 32'h0000_BEEF) begin
            n_err++; $display("FAIL concurrent_write got=%b/%h exp=1/0000beef", tx_valid[1], tx_data[63:32]);
        end
        tx_ready[1] = 1'b1;
        tick();
        tx_ready[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        tx_ready = 2'b00;
        for (int i = 0; i < 4; i++) mmio_write(32'h510, 32'h10 + 32'(i));
        wr_valid = 1'b1; wr_addr = 32'h510; wdata = 32'hEE;
        tx_ready[0] = 1'b1;
        tick();
        wr_valid = 1'b0;
        tx_ready[0] = 1'b0;
        n_cmp++; if (tx_data[31:0] !== 32'h11) begin n_err++; $display("FAIL full_pop_head got=%h exp=11", tx_data[31:0]); end
        mmio_read(32'h514, d, r, lat);
        n_cmp++; if (d !== 32'h8000_0003) begin n_err++; $display("FAIL full_pop_status got=%h exp=80000003", d); end
        mmio_read(32'h51C, d, r, lat);
        n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL full_pop_ovf got=%h exp=1", d); end
        tx_ready[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            n_cmp++;
            if (tx_data[31:0] !== 32'h10 + 32'(k)) begin n_err++; $display("FAIL full_pop_drain got=%h exp=%h", tx_data[31:0], 32'h10 + 32'(k)); end
            tick();
        end
        tx_ready[0] = 1'b0;
        n_cmp++; if (tx_valid[0] !== 1'b0) begin n_err++; $display("FAIL full_pop_dropped got=%b exp=0", tx_valid[0]); end
        mmio_write(32'h51C, 32'h1);
        mmio_write(32'h510, 32'h21);
        mmio_write(32'h510, 32'h22);
        wr_valid = 1'b1; wr_addr = 32'h510; wdata = 32'h23;
        tx_ready[0] = 1'b1;
        tick();
        wr_valid = 1'b0;
        tx_ready[0] = 1'b0;
        mmio_read(32'h514, d, r, lat);
        n_cmp++; if (d !== 32'h8000_0002) begin n_err++; $display("FAIL pushpop_level got=%h exp=80000002", d); end
        tx_ready[0] = 1'b1;
        n_cmp++; if (tx_data[31:0] !== 32'h22) begin n_err++; $display("FAIL pushpop_head got=%h exp=22", tx_data[31:0]); end
        tick();
        n_cmp++; if (tx_data[31:0] !== 32'h23) begin n_err++; $display("FAIL pushpop_tail got=%h exp=23", tx_data[31:0]); end
        tick();
        tx_ready[0] = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        mmio_write(32'h510, 32'h31);
        mmio_write(32'h510, 32'h32);
        mmio_write(32'h518, 32'h1);
        n_cmp++; if (tx_valid[0] !== 1'b0) begin n_err++; $display("FAIL flush_tx got=%b exp=0", tx_valid[0]); end
        mmio_read(32'h518, d, r, lat);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL flush_selfclear got=%h exp=0", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        mmio_write(32'h518, 32'h4);
        mmio_read(32'h518, d, r, lat);
        n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL irq_en_rb got=%h exp=4", d); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_idle got=%b exp=0", irq); end
        rx_push(0, 32'h77);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early got=%b exp=0", irq); end
        tick();
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set got=%b exp=1", irq); end
        mmio_read(32'h510, d, r, lat);
        n_cmp++; if (d !== 32'h77) begin n_err++; $display("FAIL irq_data got=%h exp=77", d); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_reset_mid_resp();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        rx_push(1, 32'h55);
        rx_push(0, 32'h56);
        mmio_write(32'h510, 32'h66);
        arvalid_q = 1'b1;
        araddr_q  = 32'h520;
        tick();
        arvalid_q = 1'b0;
        tick();
        n_cmp++; if (rvalid !== 1'b1 || irq !== 1'b1) begin n_err++; $display("FAIL midresp_pre got=%b/%b exp=1/1", rvalid, irq); end
        rst_main_sync = 1'b1;
        tick();
        rst_main_sync = 1'b0;
        n_cmp++; if (rvalid !== 1'b0 || arready !== 1'b1) begin n_err++; $display("FAIL midresp_fsm got=%b/%b exp=0/1", rvalid, arready); end
        n_cmp++; if (rdata !== 32'h0 || rresp !== 2'b00) begin n_err++; $display("FAIL midresp_rdata got=%h/%b exp=0/00", rdata, rresp); end
        n_cmp++; if (tx_valid !== 2'b00 || irq !== 1'b0) begin n_err++; $display("FAIL midresp_state got=%b/%b exp=00/0", tx_valid, irq); end
        mmio_read(32'h514, d, r, lat);
        n_cmp++; if (d !== 32'hA000_0000) begin n_err++; $display("FAIL midresp_ch0 got=%h exp=a0000000", d); end
        mmio_read(32'h518, d, r, lat);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL midresp_irq_en got=%h exp=0", d); end
    endtask

    initial begin
        rst_main_sync = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wdata     = '0;
        arvalid_q = 1'b0;
        araddr_q  = '0;
        rready    = 1'b0;
        tx_ready  = '0;
        rx_data   = '0;
        rx_valid  = '0;
        test_reset();
        test_tx_overflow();
        test_rx_read();
        test_unmapped();
        test_rready_stall();
        test_back_to_back();
        test_flush();
        test_irq();
        test_reset_mid_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_fifo_bridge.md
MMIO_FIFO_BRIDGE -- requirements
Module: mmio_fifo_bridge

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent channels, legal range 1..4.
REQ-002 SHALL have parameter DEPTH, default 16, entries per FIFO, power of two in 4..256.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0510; channel c occupies BASE_ADDR + 0x10*c through +0xF.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports as below.
- clk_main_a0  in  1  sole clock.
- rst_main_sync  in  1  synchronous reset, active-high.
- wr_valid  in  1  write strobe.
- wr_addr  in  32  write address.
- wdata  in  32  write data.
- arvalid_q  in  1  read address valid.
- araddr_q  in  32  read address.
- arready  out  1  read address accepted.
- rvalid  out  1  read data valid.
- rready  in  1  read data accept.
- rdata  out  32  read data.
- rresp  out  2  read response code.
- tx_data  out  32*NUM_CH  per-channel host-to-core data.
- tx_valid  out  NUM_CH  per-channel host-to-core valid.
- tx_ready  in  NUM_CH  per-channel host-to-core ready.
- rx_data  in  32*NUM_CH  per-channel core-to-host data.
- rx_valid  in  NUM_CH  per-channel core-to-host valid.
- rx_ready  out  NUM_CH  per-channel core-to-host ready.
- irq  out  1  registered interrupt.

Function
REQ-005 SHALL define the per-channel register map as follows.
- +0x0 DATA: write pushes the channel TX FIFO; read pops the channel RX FIFO.
- +0x4 STATUS, read-only: [8:0] tx_level, [24:16] rx_level, [28] tx_full, [29] tx_empty, [30] rx_full, [31] rx_empty, other bits 0.
- +0x8 CTRL: write bit0 flushes TX and bit1 flushes RX, both self-clearing and reading back 0; bit2 irq_en is read/write.
- +0xC STICKY: bit0 tx_ovf, bit1 rx_udf; write 1 clears.
REQ-006 SHALL contain one TX FIFO and one RX FIFO of DEPTH x 32 per channel, with levels 0..DEPTH.
REQ-007 A DATA write SHALL push only if TX is not full at that cycle; a write to a full TX SHALL be dropped and SHALL set tx_ovf.
REQ-008 TX output SHALL be first-word-fall-through.
- tx_valid[c] = !tx_empty[c]; tx_data[c] = head entry.
- Pop on tx_valid & tx_ready.
REQ-009 rx_ready[c] SHALL equal !rx_full[c]; the RX FIFO SHALL push on rx_valid & rx_ready.
REQ-010 A simultaneous push and pop on one FIFO SHALL both take effect, leaving the level unchanged; there is no pass-through when empty.
REQ-011 Flush SHALL empty the FIFO in the next cycle and SHALL win over a same-cycle push or pop.
REQ-012 Writes to STATUS, to unmapped addresses, and to reserved bits SHALL be ignored.
REQ-013 The read FSM SHALL have states IDLE, LOOKUP and RESP.
- arready = 1 only in IDLE.
- IDLE -> LOOKUP on arvalid_q, capturing araddr_q.
- LOOKUP -> RESP unconditionally.
- RESP -> IDLE on rready.
REQ-014 In LOOKUP, a DATA read SHALL behave as follows.
- RX not empty: pop once; rdata = head; rresp = 2'b00.
- RX empty: rdata = 32'hDEAD_0000; rresp = 2'b00; set rx_udf; no pop.
REQ-015 In LOOKUP, a read of an unmapped address SHALL return rdata = 32'hAAAA_AAAA and rresp = 2'b10.
REQ-016 rvalid SHALL assert exactly 2 cycles after an arvalid_q & arready handshake.
- rdata and rresp hold stable until rvalid & rready.
- rvalid deasserts the cycle after.
REQ-017 The write path SHALL be independent of the read FSM; same-cycle writes and reads to different channels SHALL both complete.
REQ-018 STICKY set and write-1-clear in the same cycle SHALL resolve with set winning.
REQ-019 irq SHALL be registered: the OR over channels of irq_en[c] & !rx_empty[c], one cycle of latency.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; level arithmetic SHALL be clog2(DEPTH)+1 bits.

Reset
REQ-021 When rst_main_sync = 1, the block SHALL reset to the following state.
- All FIFOs empty, pointers 0.
- Read FSM in IDLE, so arready = 1.
- rvalid = 0, rdata = 0, rresp = 0.
- STICKY = 0, irq_en = 0, irq = 0, tx_valid = 0.
REQ-022 Reset asserted during LOOKUP or RESP SHALL abort the response with no pop and no sticky update; it SHALL take priority over all other events.

Verification
REQ-023 The bench SHALL cover the following directed scenarios.
- DEPTH=4, ch0: 5 DATA writes 1..5 with tx_ready = 0 -> tx_level = 4, tx_full = 1, tx_ovf = 1; with tx_ready = 1, tx_data is 1,2,3,4.
- ch1 rx: push 32'hCAFE_0001, then read BASE+0x10 -> rvalid 2 cycles after handshake, rdata = 32'hCAFE_0001, rresp = 0; second read returns 32'hDEAD_0000 and rx_udf = 1.
- Read BASE+0x40 with NUM_CH = 2 -> rdata = 32'hAAAA_AAAA, rresp = 2'b10.
- rready held 0 for 5 cycles -> rvalid and rdata stable, arready = 0 throughout; IDLE is re-entered the cycle after rready.
- TX full with simultaneous write and pop -> write dropped, tx_ovf set; with level 2, simultaneous push and pop -> level stays 2.
- CTRL write 0x4 on ch0 with an RX push -> irq = 1 one cycle after rx non-empty; reset mid-RESP -> rvalid = 0 and FIFO contents cleared.
